// File: rtl/reduz_media.sv
// Block-average downscaler: reads a LARGURA x ALTURA 8-bit image and writes the truncated
// mean of each FATOR x FATOR block to the VGA frame RAM.
module reduz_media #(
  parameter int unsigned FATOR   = 2,
  parameter int unsigned LARGURA = 160,
  parameter int unsigned ALTURA  = 120,
  parameter int unsigned ADDR_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        pixel_rom,
  output logic [ADDR_W-1:0] addr_rom,
  output logic [7:0]        pixel_saida,
  output logic [ADDR_W-1:0] addr_ram_vga,
  output logic              we_ram,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LOG2F = (FATOR == 4) ? 2 : 1;
  localparam int unsigned KW    = 2 * LOG2F;
  localparam int unsigned ACCW  = 8 + KW;

  localparam logic [KW-1:0]     K_MAX  = KW'(FATOR * FATOR - 1);
  localparam logic [ADDR_W-1:0] LO_MAX = ADDR_W'(ALTURA / FATOR - 1);
  localparam logic [ADDR_W-1:0] CO_MAX = ADDR_W'(LARGURA / FATOR - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LER     = 3'd1;
  localparam logic [2:0] S_ESPERA  = 3'd2;
  localparam logic [2:0] S_ESCREVE = 3'd3;
  localparam logic [2:0] S_FIM     = 3'd4;

  logic [2:0]        r_estado, w_estado_d;
  logic [ADDR_W-1:0] r_lo, w_lo_d;
  logic [ADDR_W-1:0] r_co, w_co_d;
  logic [KW-1:0]     r_k, w_k_d;
  logic [ACCW-1:0]   r_acc, w_acc_d;
  logic [ADDR_W-1:0] r_addr_rom, w_addr_rom_d;
  logic [7:0]        r_pixel, w_pixel_d;
  logic [ADDR_W-1:0] r_addr_vga, w_addr_vga_d;
  logic              r_we, w_we_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;

  logic              w_load_addr;
  logic [ACCW-1:0]   w_soma;
  logic [ADDR_W-1:0] w_di, w_dj;

  assign w_soma = r_acc + ACCW'(pixel_rom);

  always_comb begin
    w_estado_d   = r_estado;
    w_lo_d       = r_lo;
    w_co_d       = r_co;
    w_k_d        = r_k;
    w_acc_d      = r_acc;
    w_pixel_d    = r_pixel;
    w_addr_vga_d = r_addr_vga;
    w_we_d       = r_we;
    w_busy_d     = r_busy;
    w_done_d     = r_done;
    w_load_addr  = 1'b0;

    case (r_estado)
      S_IDLE: begin
        if (start) begin
          w_estado_d  = S_LER;
          w_lo_d      = '0;
          w_co_d      = '0;
          w_k_d       = '0;
          w_acc_d     = '0;
          w_busy_d    = 1'b1;
          w_load_addr = 1'b1;
        end
      end
      S_LER: begin
        // Data returned this cycle belongs to the previous k; nothing is pending at k=0.
        if (r_k != '0) w_acc_d = w_soma;
        if (r_k == K_MAX) begin
          w_estado_d = S_ESPERA;
        end else begin
          w_k_d       = r_k + KW'(1);
          w_load_addr = 1'b1;
        end
      end
      S_ESPERA: begin
        w_acc_d      = w_soma;
        w_pixel_d    = 8'(w_soma >> KW);
        w_addr_vga_d = r_lo * ADDR_W'(LARGURA / FATOR) + r_co;
        w_we_d       = 1'b1;
        w_estado_d   = S_ESCREVE;
      end
      S_ESCREVE: begin
        w_we_d = 1'b0;
        if (r_lo == LO_MAX && r_co == CO_MAX) begin
          w_estado_d = S_FIM;
          w_busy_d   = 1'b0;
          w_done_d   = 1'b1;
        end else begin
          if (r_co == CO_MAX) begin
            w_co_d = '0;
            w_lo_d = r_lo + ADDR_W'(1);
          end else begin
            w_co_d = r_co + ADDR_W'(1);
          end
          w_k_d       = '0;
          w_acc_d     = '0;
          w_estado_d  = S_LER;
          w_load_addr = 1'b1;
        end
      end
      S_FIM: begin
        w_done_d   = 1'b0;
        w_estado_d = S_IDLE;
      end
      default: w_estado_d = S_IDLE;
    endcase
  end

  // Address of the next source pixel, from the post-update counters.
  assign w_di = ADDR_W'(w_k_d >> LOG2F);
  assign w_dj = ADDR_W'(w_k_d & KW'(FATOR - 1));

  always_comb begin
    w_addr_rom_d = r_addr_rom;
    if (w_load_addr) begin
      w_addr_rom_d = (w_lo_d * ADDR_W'(FATOR) + w_di) * ADDR_W'(LARGURA)
                   + w_co_d * ADDR_W'(FATOR) + w_dj;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= S_IDLE;
      r_lo       <= '0;
      r_co       <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_addr_rom <= '0;
      r_pixel    <= '0;
      r_addr_vga <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_estado   <= w_estado_d;
      r_lo       <= w_lo_d;
      r_co       <= w_co_d;
      r_k        <= w_k_d;
      r_acc      <= w_acc_d;
      r_addr_rom <= w_addr_rom_d;
      r_pixel    <= w_pixel_d;
      r_addr_vga <= w_addr_vga_d;
      r_we       <= w_we_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
    end
  end

  assign addr_rom     = r_addr_rom;
  assign pixel_saida  = r_pixel;
  assign addr_ram_vga = r_addr_vga;
  assign we_ram       = r_we;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_reduz_media.sv
// Directed bench for reduz_media: a 4x4/FATOR=2 instance and an 8x8/FATOR=4 instance,
// each fed by a 1-cycle-latency ROM model.
module tb_reduz_media;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FATOR=2, 4x4 instance
  logic       start2;
  logic [7:0] q2, pix2;
  logic [3:0] arom2, av2;
  logic       we2, busy2, done2;
  logic [7:0] rom2 [16];

  // FATOR=4, 8x8 instance
  logic       start4;
  logic [7:0] q4, pix4;
  logic [5:0] arom4, av4;
  logic       we4, busy4, done4;
  logic [7:0] rom4 [64];

  always @(posedge clk) q2 <= rom2[arom2];
  always @(posedge clk) q4 <= rom4[arom4];

  reduz_media #(.FATOR(2), .LARGURA(4), .ALTURA(4), .ADDR_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .pixel_rom(q2), .addr_rom(arom2),
    .pixel_saida(pix2), .addr_ram_vga(av2), .we_ram(we2), .busy(busy2), .done(done2)
  );

  reduz_media #(.FATOR(4), .LARGURA(8), .ALTURA(8), .ADDR_W(6)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .pixel_rom(q4), .addr_rom(arom4),
    .pixel_saida(pix4), .addr_ram_vga(av4), .we_ram(we4), .busy(busy4), .done(done4)
  );

  // Output monitors, sampled on the falling edge
  int   busy_cnt, busy_idx, wr_cnt, done_cnt, b2b;
  logic we_prev;
  int   wr_pix [8];
  int   wr_addr [8];
  int   wr_cyc [8];
  int   arom_log [64];
  int   w4_cnt;
  int   w4_pix [8];
  int   w4_addr [8];
  int   w4_cyc [8];

  always @(negedge clk) begin
    if (busy2) begin
      busy_cnt++;
      if (busy_idx < 64) begin
        arom_log[busy_idx] = int'(arom2);
        busy_idx++;
      end
    end
    if (we2) begin
      if (wr_cnt < 8) begin
        wr_pix[wr_cnt]  = int'(pix2);
        wr_addr[wr_cnt] = int'(av2);
        wr_cyc[wr_cnt]  = cyc;
      end
      wr_cnt++;
      if (we_prev) b2b++;
    end
    we_prev = we2;
    if (done2) done_cnt++;
    if (we4) begin
      if (w4_cnt < 8) begin
        w4_pix[w4_cnt]  = int'(pix4);
        w4_addr[w4_cnt] = int'(av4);
        w4_cyc[w4_cnt]  = cyc;
      end
      w4_cnt++;
    end
  end

  int n_asrt = 0;
  int n_fail = 0;
  int t_start, t_done;
  bit ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon();
    busy_cnt = 0; busy_idx = 0; wr_cnt = 0; done_cnt = 0; b2b = 0; we_prev = 1'b0;
    w4_cnt = 0;
  endtask

  task automatic pulse2();
    step();
    t_start = cyc;
    start2  = 1'b1;
    step();
    start2  = 1'b0;
  endtask

  task automatic wait_done2(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done2 === 1'b1) begin
        found  = 1'b1;
        t_done = cyc;
        break;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input int e0, input int e1, input int e2,
                           input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_nwr"}, wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_pix%0d", tag, i), wr_pix[i], e[i]);
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_addr_rom"}, arom2, 0);
    chk({tag, "_pixel_saida"}, pix2, 0);
    chk({tag, "_addr_ram_vga"}, av2, 0);
    chk({tag, "_we_ram"}, we2, 0);
    chk({tag, "_busy"}, busy2, 0);
    chk({tag, "_done"}, done2, 0);
  endtask

  int grp [3] = '{0, 1, 3};
  int ea [12] = '{0, 1, 4, 5, 2, 3, 6, 7, 10, 11, 14, 15};
  bit hit;

  initial begin
    rst = 1'b1; start2 = 1'b0; start4 = 1'b0;
    for (int i = 0; i < 16; i++) rom2[i] = 8'd0;
    for (int i = 0; i < 64; i++) rom4[i] = 8'(i);
    clr_mon();
    repeat (3) step();
    chk_outs_zero("reset");
    rst = 1'b0;
    step();

    // Constant image
    for (int i = 0; i < 16; i++) rom2[i] = 8'd100;
    clr_mon();
    pulse2();
    wait_done2(60, ok);
    chk("const_done_seen", ok, 1);
    chk("const_done_latency", t_done - t_start, 25);
    repeat (3) step();
    chk("const_busy_cycles", busy_cnt, 24);
    chk_frame("const", 100, 100, 100, 100);
    chk("const_we_b2b", b2b, 0);
    chk("const_done_pulses", done_cnt, 1);
    chk("const_pixel_period", wr_cyc[1] - wr_cyc[0], 6);

    // Ramp image: address order and averages
    for (int i = 0; i < 16; i++) rom2[i] = 8'(i);
    clr_mon();
    pulse2();
    wait_done2(60, ok);
    chk("ramp_done_seen", ok, 1);
    repeat (3) step();
    chk_frame("ramp", 2, 4, 10, 12);
    for (int j = 0; j < 3; j++)
      for (int d = 0; d < 4; d++)
        chk($sformatf("ramp_arom_b%0d_k%0d", grp[j], d), arom_log[grp[j] * 6 + d],
            ea[j * 4 + d]);

    // Truncation, then saturating-range sum
    for (int i = 0; i < 16; i++) rom2[i] = 8'd255;
    rom2[5] = 8'd254;
    clr_mon();
    pulse2();
    wait_done2(60, ok);
    repeat (3) step();
    chk_frame("trunc", 254, 255, 255, 255);
    rom2[5] = 8'd255;
    clr_mon();
    pulse2();
    wait_done2(60, ok);
    repeat (3) step();
    chk_frame("all255", 255, 255, 255, 255);

    // start mid-frame and during the done cycle must be ignored
    for (int i = 0; i < 16; i++) rom2[i] = 8'(i);
    clr_mon();
    pulse2();
    repeat (10) step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    wait_done2(60, ok);
    chk("restart_done_seen", ok, 1);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (40) step();
    chk_frame("restart", 2, 4, 10, 12);
    chk("restart_done_pulses", done_cnt, 1);
    chk("restart_busy_idle", busy2, 0);

    // Reset during the second write cycle
    clr_mon();
    pulse2();
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (we2 === 1'b1 && wr_cnt == 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rstmid_reached_2nd_write", hit, 1);
    #1 rst = 1'b1;
    #1;
    chk_outs_zero("rstmid");
    step();
    step();
    rst = 1'b0;
    repeat (40) step();
    chk("rstmid_no_more_writes", wr_cnt, 2);
    chk("rstmid_busy_idle", busy2, 0);
    clr_mon();
    pulse2();
    wait_done2(60, ok);
    chk("rstmid_new_done_seen", ok, 1);
    repeat (3) step();
    chk_frame("rstmid_new", 2, 4, 10, 12);

    // FATOR=4 on an 8x8 ramp
    clr_mon();
    step();
    t_start = cyc;
    start4  = 1'b1;
    step();
    start4  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done4 === 1'b1) begin
        ok     = 1'b1;
        t_done = cyc;
        break;
      end
    end
    chk("f4_done_seen", ok, 1);
    chk("f4_done_latency", t_done - t_start, 73);
    repeat (3) step();
    chk("f4_nwr", w4_cnt, 4);
    chk("f4_pix0", w4_pix[0], 13);
    chk("f4_pix1", w4_pix[1], 17);
    chk("f4_pix2", w4_pix[2], 45);
    chk("f4_pix3", w4_pix[3], 49);
    chk("f4_addr3", w4_addr[3], 3);
    chk("f4_pixel_period", w4_cyc[1] - w4_cyc[0], 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
